// File: rtl/ej32_mem_io.sv
// ej32_mem_io: byte-wide memory at the far end of the eJ32 load/store bus.
// Port A (core) gets a 1-cycle registered read and a single-edge write.
// Port B moves bytes between an external RX stream and the TIB window, and
// between the OBUF window and an external TX stream.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   addr_i, asel_i, we_i     core byte address, data(1)/fetch(0) select, write enable
//   data_i, data_o           core write byte, registered read byte (cycle after addr_i)
//   rx_valid/rx_data/rx_ready  RX byte stream into TIB
//   tx_valid/tx_data/tx_ready  TX byte stream out of OBUF
//   rx_cnt, tx_cnt           unread TIB bytes, undrained OBUF bytes
module ej32_mem_io #(
  parameter int unsigned TIB       = 32'h1000,
  parameter int unsigned OBUF      = 32'h1400,
  parameter int unsigned BSZ       = 32'h400,
  parameter int unsigned MEM_DEPTH = 32'h2000,
  parameter int unsigned ASZ       = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ASZ-1:0]         addr_i,
  input  logic                   asel_i,
  input  logic                   we_i,
  input  logic [7:0]             data_i,
  output logic [7:0]             data_o,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [$clog2(BSZ):0]   rx_cnt,
  output logic [$clog2(BSZ):0]   tx_cnt
);

  localparam int unsigned PW = $clog2(BSZ);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned MW = $clog2(MEM_DEPTH);

  localparam logic [ASZ-1:0] TIB_A    = ASZ'(TIB);
  localparam logic [ASZ-1:0] TIB_END  = ASZ'(TIB + BSZ);
  localparam logic [ASZ-1:0] OBUF_A   = ASZ'(OBUF);
  localparam logic [ASZ-1:0] OBUF_END = ASZ'(OBUF + BSZ);
  localparam logic [ASZ-1:0] DEPTH_A  = ASZ'(MEM_DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(BSZ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_WR   = 2'd1,
    TX_RD   = 2'd2,
    TX_HOLD = 2'd3
  } state_t;

  logic [7:0] mem [MEM_DEPTH];

  state_t          state, state_d;
  logic            rx_pend, rx_pend_d;
  logic [7:0]      rx_byte, rx_byte_d;
  logic [PW-1:0]   rx_wp, rx_wp_d;
  logic [PW-1:0]   tx_rp, tx_rp_d;
  logic [CW-1:0]   rx_cnt_d, tx_cnt_d;
  logic            rx_ready_d;
  logic            tx_valid_d;
  logic            tx_load;

  logic            a_mapped, a_we;
  logic [MW-1:0]   a_idx;
  logic            core_tib_rd, core_obuf_wr;
  logic [ASZ-1:0]  rx_addr;
  logic [MW-1:0]   rx_idx, tx_idx;
  logic            b_we, rx_acc, tx_drain;
  logic            rx_inc, rx_dec, tx_inc, tx_dec;
  logic [7:0]      a_rd_data, tx_rd_data;

  // Port A decode: mapped range and window hits for the counters
  always_comb begin
    a_mapped     = addr_i < DEPTH_A;
    a_idx        = addr_i[MW-1:0];
    a_we         = we_i & a_mapped;
    core_tib_rd  = asel_i & ~we_i & (addr_i >= TIB_A) & (addr_i < TIB_END);
    core_obuf_wr = asel_i & we_i & (addr_i >= OBUF_A) & (addr_i < OBUF_END);
  end

  // Port B addressing; an RX write yields for one cycle to a core write of the same byte
  always_comb begin
    rx_addr  = TIB_A + ASZ'(rx_wp);
    rx_idx   = rx_addr[MW-1:0];
    tx_idx   = MW'(OBUF) + MW'(tx_rp);
    b_we     = rx_pend & ~(we_i & (addr_i == rx_addr));
    rx_acc   = rx_valid & rx_ready;
    tx_drain = (state == TX_HOLD) & tx_ready;
  end

  // Read muxes, write-first against any same-edge write
  always_comb begin
    a_rd_data = 8'h00;
    if (a_mapped) begin
      if (b_we && (rx_idx == a_idx)) a_rd_data = rx_byte;
      else                           a_rd_data = mem[a_idx];
    end
    if (a_we && (a_idx == tx_idx)) tx_rd_data = data_i;
    else                           tx_rd_data = mem[tx_idx];
  end

  // Port B next state; the pending RX byte is written whenever it is not stalled
  always_comb begin
    state_d    = state;
    rx_pend_d  = rx_pend;
    rx_byte_d  = rx_byte;
    rx_wp_d    = rx_wp;
    tx_rp_d    = tx_rp;
    tx_valid_d = tx_valid;
    tx_load    = 1'b0;

    if (b_we) begin
      rx_pend_d = 1'b0;
      rx_wp_d   = rx_wp + PW'(1);
    end
    if (rx_acc) begin
      rx_pend_d = 1'b1;
      rx_byte_d = rx_data;
    end

    case (state)
      IDLE: begin
        if (rx_acc) begin
          state_d = RX_WR;
        end else if (!rx_pend && (tx_cnt != '0) && !tx_valid) begin
          state_d = TX_RD;
        end
      end
      RX_WR: begin
        if (b_we) state_d = IDLE;
      end
      TX_RD: begin
        tx_load    = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = TX_HOLD;
      end
      TX_HOLD: begin
        if (tx_drain) begin
          tx_valid_d = 1'b0;
          tx_rp_d    = tx_rp + PW'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy counters; simultaneous +1/-1 cancel
  always_comb begin
    rx_inc = b_we;
    rx_dec = core_tib_rd & (rx_cnt != '0);
    tx_inc = core_obuf_wr & (tx_cnt != FULL_CNT);
    tx_dec = tx_drain;

    rx_cnt_d = rx_cnt;
    if (rx_inc && !rx_dec)      rx_cnt_d = rx_cnt + CW'(1);
    else if (!rx_inc && rx_dec) rx_cnt_d = rx_cnt - CW'(1);

    tx_cnt_d = tx_cnt;
    if (tx_inc && !tx_dec)      tx_cnt_d = tx_cnt + CW'(1);
    else if (!tx_inc && tx_dec) tx_cnt_d = tx_cnt - CW'(1);

    // One byte in flight at most: a pending byte already holds its TIB slot
    rx_ready_d = !rx_pend_d && (rx_cnt_d < FULL_CNT) &&
                 ((state_d == IDLE) || (state_d == TX_HOLD));
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rx_pend  <= 1'b0;
      rx_byte  <= 8'h00;
      rx_wp    <= '0;
      tx_rp    <= '0;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      data_o   <= 8'h00;
    end else begin
      state    <= state_d;
      rx_pend  <= rx_pend_d;
      rx_byte  <= rx_byte_d;
      rx_wp    <= rx_wp_d;
      tx_rp    <= tx_rp_d;
      rx_cnt   <= rx_cnt_d;
      tx_cnt   <= tx_cnt_d;
      rx_ready <= rx_ready_d;
      tx_valid <= tx_valid_d;
      if (tx_load) tx_data <= tx_rd_data;
      if (!we_i)   data_o  <= a_rd_data;
    end
  end

  // Storage: contents survive reset; port A is listed last so it wins any tie
  always_ff @(posedge clk) begin
    if (b_we) mem[rx_idx] <= rx_byte;
    if (a_we) mem[a_idx]  <= data_i;
  end

endmodule

// File: tb/tb_ej32_mem_io.sv
module tb_ej32_mem_io;

  localparam int TIB       = 'h1000;
  localparam int OBUF      = 'h1400;
  localparam int BSZ       = 'h400;
  localparam int MEM_DEPTH = 'h2000;

  logic        clk, rst;
  logic [16:0] addr_i;
  logic        asel_i, we_i;
  logic [7:0]  data_i, data_o;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic [10:0] rx_cnt, tx_cnt;

  ej32_mem_io dut (
    .clk(clk), .rst(rst),
    .addr_i(addr_i), .asel_i(asel_i), .we_i(we_i), .data_i(data_i), .data_o(data_o),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_cnt(rx_cnt), .tx_cnt(tx_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] ref_mem [MEM_DEPTH];
  bit         known   [MEM_DEPTH];
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  int         rx_m = 0;
  int         tx_m = 0;
  int         rx_total = 0;
  int         tx_wr_idx = 0;
  bit         chk_rd = 0;
  int         tx_mode = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // TX sink behaviour
  initial begin
    tx_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_mode == 0)      tx_ready = 0;
      else if (tx_mode == 1) tx_ready = 1;
      else                   tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: read responses and TX stream against the scoreboard queues
  initial begin : monitor
    bit         rd_pend_mon;
    bit         hold;
    logic [7:0] held;
    rd_pend_mon = 0;
    hold = 0;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_pend_mon = 0;
        hold = 0;
      end else begin
        if (rd_pend_mon) begin
          if (rd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_scoreboard_empty actual=%0h", data_o);
          end else begin
            chk("data_o", 32'(data_o), 32'(rd_q.pop_front()));
          end
        end
        rd_pend_mon = chk_rd && !we_i;
        if (tx_valid && tx_ready) begin
          if (tx_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected actual=%0h expected=none", tx_data);
          end else begin
            chk("tx_stream", 32'(tx_data), 32'(tx_q.pop_front()));
            tx_m--;
          end
          hold = 0;
        end else if (tx_valid) begin
          if (hold) chk("tx_data_stable", 32'(tx_data), 32'(held));
          held = tx_data;
          hold = 1;
        end else begin
          hold = 0;
        end
      end
    end
  end

  task automatic clear_model();
    foreach (known[i]) known[i] = 0;
    rd_q.delete();
    tx_q.delete();
    rx_m = 0; tx_m = 0; rx_total = 0; tx_wr_idx = 0;
  endtask

  task automatic core_op(input bit we, input bit asel, input logic [16:0] a,
                         input logic [7:0] d, input bit chk_en);
    bit mapped;
    int ai;
    ai = int'(a);
    mapped = ai < MEM_DEPTH;
    addr_i = a; asel_i = asel; we_i = we; data_i = d;
    if (!we && chk_en) begin
      if (!mapped) begin
        rd_q.push_back(8'h00); chk_rd = 1;
      end else if (known[ai]) begin
        rd_q.push_back(ref_mem[ai]); chk_rd = 1;
      end
    end
    step();
    chk_rd = 0; we_i = 0; asel_i = 0; addr_i = '0; data_i = '0;
    if (we && mapped) begin
      ref_mem[ai] = d; known[ai] = 1;
    end
    if (asel && !we && ai >= TIB && ai < TIB + BSZ && rx_m > 0) rx_m--;
    if (asel && we && ai >= OBUF && ai < OBUF + BSZ && tx_m < BSZ) tx_m++;
  endtask

  task automatic obuf_write(input logic [7:0] d);
    logic [16:0] a;
    a = 17'(OBUF + (tx_wr_idx % BSZ));
    if (tx_m < BSZ) tx_q.push_back(d);
    tx_wr_idx++;
    core_op(1, 1, a, d, 0);
  endtask

  task automatic push_rx(input logic [7:0] b, input bit collide);
    int n;
    int idx;
    n = 0;
    rx_valid = 1; rx_data = b;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 64) begin
        checks++; failures++;
        $display("FAIL rx_ready_timeout actual=0 expected=1");
        rx_valid = 0;
        return;
      end
    end
    step();
    rx_valid = 0;
    idx = TIB + (rx_total % BSZ);
    rx_total++;
    if (collide) begin
      addr_i = 17'(idx); asel_i = 1; we_i = 1; data_i = ~b;
      step();
      we_i = 0; asel_i = 0; addr_i = '0; data_i = '0;
    end
    step();
    ref_mem[idx] = b; known[idx] = 1;
    rx_m++;
    chk("rx_cnt_push", 32'(rx_cnt), 32'(rx_m));
    if (collide) core_op(0, 0, 17'(idx), 0, 1);
  endtask

  task automatic wait_tx_valid(input int limit);
    int n;
    n = 0;
    while (!tx_valid) begin
      step();
      n++;
      if (n > limit) begin
        checks++; failures++;
        $display("FAIL tx_valid_timeout actual=0 expected=1");
        return;
      end
    end
  endtask

  task automatic wait_tx_drained(input int limit);
    int n;
    n = 0;
    while (tx_q.size() != 0 || tx_valid) begin
      step();
      n++;
      if (n > limit) begin
        checks++; failures++;
        $display("FAIL tx_drain_timeout actual=%0d expected=0", tx_q.size());
        return;
      end
    end
    step();
    chk("tx_cnt_drained", 32'(tx_cnt), 32'(0));
  endtask

  task automatic do_reset();
    chk_rd = 0;
    rst = 0;
    step();
    step();
    chk("rst_data_o", 32'(data_o), 0);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_rx_cnt", 32'(rx_cnt), 0);
    chk("rst_tx_cnt", 32'(tx_cnt), 0);
    clear_model();
    rst = 1;
    step();
    step();
    chk("rx_ready_after_rst", 32'(rx_ready), 1);
  endtask

  initial begin : main
    logic [7:0] b0, b1, b2;
    logic [7:0] first_rx;
    int         op;
    int         lim;
    rst = 1; addr_i = '0; asel_i = 0; we_i = 0; data_i = '0;
    rx_valid = 0; rx_data = '0;
    #3;
    do_reset();

    // Basic write then read with 1-cycle latency; data_o holds across a write
    core_op(1, 1, 17'h0010, 8'hA5, 0);
    core_op(0, 1, 17'h0010, 0, 1);
    core_op(1, 1, 17'h0011, 8'h5A, 0);
    chk("data_o_hold_on_write", 32'(data_o), 32'h0A5);
    core_op(0, 0, 17'h0011, 0, 1);

    // RX fill into TIB and core consumption
    push_rx(8'h41, 0);
    push_rx(8'h42, 0);
    chk("rx_cnt_two", 32'(rx_cnt), 2);
    core_op(0, 1, 17'(TIB), 0, 1);
    chk("rx_cnt_after_read", 32'(rx_cnt), 1);
    core_op(0, 1, 17'(TIB + 1), 0, 1);
    chk("rx_cnt_after_read2", 32'(rx_cnt), 0);
    core_op(0, 1, 17'(TIB), 0, 1);
    chk("rx_cnt_saturate", 32'(rx_cnt), 0);

    // OBUF drain with free-flowing sink
    tx_mode = 1;
    obuf_write(8'h48);
    obuf_write(8'h49);
    wait_tx_drained(50);

    // Back-pressured sink holds the first byte steady
    tx_mode = 0;
    step(); step();
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    obuf_write(b0); obuf_write(b1); obuf_write(b2);
    repeat (6) step();
    chk("tx_valid_held", 32'(tx_valid), 1);
    chk("tx_cnt_held", 32'(tx_cnt), 3);
    chk("tx_data_held", 32'(tx_data), 32'(b0));
    repeat (4) step();
    chk("tx_data_still", 32'(tx_data), 32'(b0));
    tx_mode = 1;
    wait_tx_drained(50);

    // Randomized mix against the model
    tx_mode = 2;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: core_op(1, 1, 17'($urandom_range(0, 255)), 8'($urandom), 0);
        1: core_op(0, 1'($urandom_range(0, 1)), 17'($urandom_range(0, 255)), 0, 1);
        2: core_op(1'($urandom_range(0, 1)), 1, 17'($urandom_range('h2000, 'h1FFFF)),
                   8'($urandom), 1);
        3: if (tx_q.size() < 16) obuf_write(8'($urandom));
        4: if (rx_m < BSZ - 1) push_rx(8'($urandom), $urandom_range(0, 3) == 0);
        5: begin
          lim = (rx_total < BSZ) ? rx_total : BSZ;
          if (lim == 0) lim = 1;
          core_op(0, 1, 17'(TIB + $urandom_range(0, lim - 1)), 0, 1);
        end
        default: step();
      endcase
      chk("rx_cnt_rand", 32'(rx_cnt), 32'(rx_m));
    end
    tx_mode = 1;
    wait_tx_drained(500);

    // Fill TIB completely, then wrap after one consumption
    do_reset();
    first_rx = 8'($urandom);
    push_rx(first_rx, 0);
    for (int i = 1; i < BSZ; i++) push_rx(8'($urandom), 0);
    step();
    chk("rx_cnt_full", 32'(rx_cnt), 32'(BSZ));
    chk("rx_ready_full", 32'(rx_ready), 0);
    core_op(0, 1, 17'(TIB), 0, 1);
    chk("rx_cnt_after_full_read", 32'(rx_cnt), 32'(BSZ - 1));
    push_rx(8'hC3, 0);
    core_op(0, 0, 17'(TIB), 0, 1);
    chk("rx_wrap_byte_known", 32'(known[TIB]), 1);

    // Asynchronous reset while a TX byte is held
    tx_mode = 0;
    obuf_write(8'h5C);
    obuf_write(8'h6D);
    wait_tx_valid(20);
    chk("tx_cnt_before_rst", 32'(tx_cnt), 2);
    core_op(1, 1, 17'h0010, 8'hA5, 0);
    core_op(0, 1, 17'h0010, 0, 1);
    chk("data_o_before_rst", 32'(data_o), 32'h0A5);
    @(negedge clk);
    #2;
    rst = 0;
    #1;
    chk("async_tx_valid", 32'(tx_valid), 0);
    chk("async_tx_cnt", 32'(tx_cnt), 0);
    chk("async_data_o", 32'(data_o), 0);
    chk("async_tx_data", 32'(tx_data), 0);
    chk("async_rx_ready", 32'(rx_ready), 0);
    clear_model();
    @(posedge clk);
    #1;
    rst = 1;
    step();
    step();
    chk("post_rst_tx_valid", 32'(tx_valid), 0);
    chk("post_rst_rx_ready", 32'(rx_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
